conv_slice_ctrl: RTL and testbench

CONV_SLICE_CTRL -- requirements
Module: conv_slice_ctrl

---
 rtl/conv_slice_ctrl_if.sv | 29 ++
 rtl/conv_slice_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_conv_slice_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_slice_ctrl_if.sv
// Slice and PE-array handshake bundle for conv_slice_ctrl.
// The master side is the controller; the slave side is the slice plus the PE array.
interface conv_slice_ctrl_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int COLUMN_WIDTH = 9
);
   localparam int BEAT_W = DATA_WIDTH * COLUMN_WIDTH;

   logic              conv_en;
   logic [2:0]        kernel;
   logic              image_read;
   logic              image_valid;
   logic [BEAT_W-1:0] image_data;
   logic              im_valid_del;
   logic              sudo_reset;
   logic              pe_ready;
   logic              pe_valid;
   logic [BEAT_W-1:0] pe_data;

   modport master (
      output conv_en, kernel, image_read, im_valid_del, sudo_reset, pe_valid, pe_data,
      input  image_valid, image_data, pe_ready
   );

   modport slave (
      input  conv_en, kernel, image_read, im_valid_del, sudo_reset, pe_valid, pe_data,
      output image_valid, image_data, pe_ready
   );
endinterface

// File: rtl/conv_slice_ctrl.sv
// Job sequencer for one convolution slice: fill, stream beats to the PE array, clear, repeat.
// Optional fill watchdog is compiled in with `define SLICE_CTRL_TIMEOUT_EN.
module conv_slice_ctrl #(
   parameter int DATA_WIDTH   = 16,
   parameter int COLUMN_WIDTH = 9,
   parameter int IMAGE_COUNT  = 10,
   parameter int WDOG_CYCLES  = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [2:0]              kernel_cfg,
   input  logic [7:0]              num_passes,
   input  logic                    abort,
   input  logic                    im2col_valid,
   conv_slice_ctrl_if.master       slc,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   localparam int         BEAT_W    = DATA_WIDTH * COLUMN_WIDTH;
   localparam logic [5:0] FILL_LAST = 6'(IMAGE_COUNT - 1);
   localparam logic [5:0] TGT_K3    = 6'(IMAGE_COUNT);
   localparam logic [5:0] TGT_K6    = 6'(4 * IMAGE_COUNT);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_FILL   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_CLEAR  = 3'd5,
      ST_FIN    = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        fill_q, fill_d;
   logic [5:0]        iss_q, iss_d;
   logic [5:0]        rcv_q, rcv_d;
   logic [7:0]        pass_q, pass_d;
   logic [7:0]        np_q, np_d;
   logic [2:0]        kernel_q, kernel_d;
   logic              err_q, err_d;
   logic              sudo_q, sudo_d;
   logic              conv_en_q, conv_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ivd_q, ivd_d;
   logic              pe_valid_q, pe_valid_d;
   logic [BEAT_W-1:0] pe_data_q, pe_data_d;

   logic              image_read_s;
   logic              beat_window_s;
   logic              beat_ok_s;
   logic [5:0]        target_s;
   logic [7:0]        np_eff_s;

`ifdef SLICE_CTRL_TIMEOUT_EN
   localparam int            WD_W      = $clog2(WDOG_CYCLES + 1);
   localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
`endif

   function automatic logic [5:0] sat_inc6(input logic [5:0] v);
      if (v == 6'h3f) begin
         return v;
      end else begin
         return v + 6'd1;
      end
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hff) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   // Next-state, counters, error and request decode.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      iss_d     = iss_q;
      rcv_d     = rcv_q;
      pass_d    = pass_q;
      np_d      = np_q;
      kernel_d  = kernel_q;
      err_d     = err_q;
      sudo_d    = 1'b0;
      target_s  = (kernel_q == 3'd6) ? TGT_K6 : TGT_K3;
      np_eff_s  = (np_q == 8'd0) ? 8'd1 : np_q;

      image_read_s  = (state_q == ST_STREAM) && (iss_q < target_s) && slc.pe_ready && !abort;
      beat_window_s = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && (rcv_q < iss_q);
      beat_ok_s     = slc.image_valid && beat_window_s && !abort;

      if (image_read_s) begin
         iss_d = sat_inc6(iss_q);
      end else begin
         iss_d = iss_q;
      end
      if (beat_ok_s) begin
         rcv_d = sat_inc6(rcv_q);
      end else begin
         rcv_d = rcv_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start && ((kernel_cfg == 3'd3) || (kernel_cfg == 3'd6))) begin
               kernel_d = kernel_cfg;
               np_d     = num_passes;
               pass_d   = 8'd0;
               fill_d   = 6'd0;
               iss_d    = 6'd0;
               rcv_d    = 6'd0;
               err_d    = 1'b0;
               state_d  = ST_ARM;
            end else if (start) begin
               err_d    = 1'b1;
               sudo_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_ARM: begin
            state_d = ST_FILL;
         end
         ST_FILL: begin
            if (im2col_valid) begin
               fill_d = sat_inc6(fill_q);
               if (fill_q == FILL_LAST) begin
                  state_d = ST_STREAM;
               end else begin
                  state_d = ST_FILL;
               end
            end
`ifdef SLICE_CTRL_TIMEOUT_EN
            else if (wdog_q == WDOG_LAST) begin
               err_d   = 1'b1;
               sudo_d  = 1'b1;
               fill_d  = 6'd0;
               state_d = ST_IDLE;
            end
`endif
            else begin
               state_d = ST_FILL;
            end
         end
         ST_STREAM: begin
            if (iss_d == target_s) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if (rcv_d == target_s) begin
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_CLEAR: begin
            pass_d = sat_inc8(pass_q);
            fill_d = 6'd0;
            iss_d  = 6'd0;
            rcv_d  = 6'd0;
            if (pass_d < np_eff_s) begin
               state_d = ST_FILL;
            end else begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            fill_d  = 6'd0;
            iss_d   = 6'd0;
            rcv_d   = 6'd0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over every transition computed above.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         sudo_d  = 1'b1;
         fill_d  = 6'd0;
         iss_d   = 6'd0;
         rcv_d   = 6'd0;
         pass_d  = 8'd0;
      end else begin
         sudo_d  = sudo_d;
      end

      // A beat nobody asked for is flagged and dropped, even on the cycle a start is accepted.
      if (slc.image_valid && !beat_window_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_d;
      end
   end

   // Output decode from the upcoming state so every status output comes straight off a flop.
   always_comb begin
      conv_en_d  = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      ivd_d      = 1'b0;
      pe_valid_d = beat_ok_s;
      if (beat_ok_s) begin
         pe_data_d = slc.image_data;
      end else begin
         pe_data_d = pe_data_q;
      end
      case (state_d)
         ST_IDLE:   busy_d    = 1'b0;
         ST_ARM:    conv_en_d = 1'b1;
         ST_FILL:   conv_en_d = 1'b1;
         ST_STREAM: conv_en_d = 1'b1;
         ST_DRAIN:  conv_en_d = 1'b1;
         ST_CLEAR: begin
            conv_en_d = 1'b1;
            ivd_d     = 1'b1;
         end
         ST_FIN:    done_d    = 1'b1;
         default:   busy_d    = 1'b0;
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         fill_q     <= 6'd0;
         iss_q      <= 6'd0;
         rcv_q      <= 6'd0;
         pass_q     <= 8'd0;
         np_q       <= 8'd0;
         kernel_q   <= 3'd0;
         err_q      <= 1'b0;
         sudo_q     <= 1'b0;
         conv_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ivd_q      <= 1'b0;
         pe_valid_q <= 1'b0;
         pe_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         iss_q      <= iss_d;
         rcv_q      <= rcv_d;
         pass_q     <= pass_d;
         np_q       <= np_d;
         kernel_q   <= kernel_d;
         err_q      <= err_d;
         sudo_q     <= sudo_d;
         conv_en_q  <= conv_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ivd_q      <= ivd_d;
         pe_valid_q <= pe_valid_d;
         pe_data_q  <= pe_data_d;
      end
   end

`ifdef SLICE_CTRL_TIMEOUT_EN
   // Watchdog restarts on every fill pulse and whenever FILL is (re)entered.
   always_comb begin
      if ((state_q == ST_FILL) && !im2col_valid) begin
         wdog_d = wdog_q + WD_W'(1);
      end else begin
         wdog_d = '0;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`endif

   assign slc.conv_en      = conv_en_q;
   assign slc.kernel       = kernel_q;
   assign slc.image_read   = image_read_s;
   assign slc.im_valid_del = ivd_q;
   assign slc.sudo_reset   = sudo_q;
   assign slc.pe_valid     = pe_valid_q;
   assign slc.pe_data      = pe_data_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
endmodule

// File: tb/tb_conv_slice_ctrl.sv
// Directed bench for conv_slice_ctrl: a one-cycle-latency slice model feeds beats tagged with a
// running sequence number, and every forwarded beat is checked in order.
module tb_conv_slice_ctrl;
   localparam int DW = 16;
   localparam int CW = 9;
   localparam int BW = DW * CW;
   localparam int IC = 10;

   logic       clk;
   logic       reset;
   logic       start;
   logic [2:0] kernel_cfg;
   logic [7:0] num_passes;
   logic       abort;
   logic       im2col_valid;
   logic       busy;
   logic       done;
   logic       err;

   conv_slice_ctrl_if #(.DATA_WIDTH(DW), .COLUMN_WIDTH(CW)) slc ();

   conv_slice_ctrl #(
      .DATA_WIDTH(DW), .COLUMN_WIDTH(CW), .IMAGE_COUNT(IC), .WDOG_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .kernel_cfg(kernel_cfg),
      .num_passes(num_passes), .abort(abort), .im2col_valid(im2col_valid),
      .slc(slc), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slice model: answers each image_read one cycle later; stray injects an unrequested beat.
   logic [15:0] slice_seq = 16'd0;
   logic        stray = 1'b0;
   always @(posedge clk) begin
      slc.image_valid <= slc.image_read | stray;
      if (slc.image_read) begin
         slc.image_data <= {CW{slice_seq}};
         slice_seq      <= slice_seq + 16'd1;
      end
   end

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_beat = 0;
   int          n_ivd = 0;
   int          n_done = 0;
   int          n_sudo = 0;
   int          n_rd = 0;
   int          n_badrd = 0;
   logic [15:0] exp_seq = 16'd0;

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and account for everything the DUT showed there.
   task automatic cyc();
      @(negedge clk);
      if (slc.pe_valid) begin
         chk("pe_data_order", slc.pe_data, {CW{exp_seq}});
         exp_seq = exp_seq + 16'd1;
         n_beat++;
      end
      if (slc.im_valid_del) n_ivd++;
      if (done) n_done++;
      if (slc.sudo_reset) n_sudo++;
      if (slc.image_read) n_rd++;
      if (slc.image_read && !slc.pe_ready) n_badrd++;
   endtask

   task automatic fill_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         im2col_valid = 1'b1;
         cyc();
      end
      im2col_valid = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [2:0] k, input logic [7:0] np,
                          input bit tog, input int passes, input int beats);
      int b0, i0, d0, s0, r0, x0, t;
      b0 = n_beat; i0 = n_ivd; d0 = n_done; s0 = n_sudo; r0 = n_rd; x0 = n_badrd;
      start = 1'b1; kernel_cfg = k; num_passes = np;
      cyc();
      start = 1'b0;
      chk({tag, "_arm_busy"}, BW'(busy), BW'(1));
      chk({tag, "_arm_conv_en"}, BW'(slc.conv_en), BW'(1));
      chk({tag, "_kernel"}, BW'(slc.kernel), BW'(k));
      chk({tag, "_err_cleared"}, BW'(err), BW'(0));
      cyc();
      for (int p = 0; p < passes; p++) begin
         int iv;
         fill_pulses(IC);
         iv = n_ivd;
         t = 0;
         while ((n_ivd == iv) && (t < 400)) begin
            if (tog) slc.pe_ready = ~slc.pe_ready;
            cyc();
            t++;
         end
         slc.pe_ready = 1'b1;
         chk({tag, "_clear_reached"}, BW'(n_ivd - iv), BW'(1));
         cyc();
      end
      cyc();
      chk({tag, "_beats"}, BW'(n_beat - b0), BW'(beats));
      chk({tag, "_reads"}, BW'(n_rd - r0), BW'(beats));
      chk({tag, "_read_wo_ready"}, BW'(n_badrd - x0), BW'(0));
      chk({tag, "_ivd_pulses"}, BW'(n_ivd - i0), BW'(passes));
      chk({tag, "_done_pulses"}, BW'(n_done - d0), BW'(1));
      chk({tag, "_sudo_pulses"}, BW'(n_sudo - s0), BW'(0));
      chk({tag, "_busy_end"}, BW'(busy), BW'(0));
      chk({tag, "_err_end"}, BW'(err), BW'(0));
   endtask

   initial begin
      int b0, d0, t;
      reset = 1'b0; start = 1'b0; kernel_cfg = 3'd0; num_passes = 8'd0;
      abort = 1'b0; im2col_valid = 1'b0; slc.pe_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_conv_en", BW'(slc.conv_en), BW'(0));
      chk("rst_kernel", BW'(slc.kernel), BW'(0));
      chk("rst_image_read", BW'(slc.image_read), BW'(0));
      chk("rst_ivd", BW'(slc.im_valid_del), BW'(0));
      chk("rst_sudo", BW'(slc.sudo_reset), BW'(0));
      chk("rst_pe_valid", BW'(slc.pe_valid), BW'(0));
      chk("rst_pe_data", slc.pe_data, BW'(0));
      chk("rst_busy", BW'(busy), BW'(0));
      chk("rst_done", BW'(done), BW'(0));
      chk("rst_err", BW'(err), BW'(0));
      reset = 1'b1;
      cyc();
      chk("post_rst_pulses", BW'({done, slc.sudo_reset, slc.im_valid_del}), BW'(0));

      run_job("k3_p1", 3'd3, 8'd1, 1'b0, 1, 10);
      run_job("k6_p2", 3'd6, 8'd2, 1'b0, 2, 80);
      run_job("k6_toggle", 3'd6, 8'd1, 1'b1, 1, 40);
      run_job("k3_p0", 3'd3, 8'd0, 1'b0, 1, 10);

      // Start during a job is ignored, then abort after five beats.
      start = 1'b1; kernel_cfg = 3'd3; num_passes = 8'd1;
      cyc();
      start = 1'b0;
      cyc();
      start = 1'b1; kernel_cfg = 3'd5;
      cyc();
      start = 1'b0;
      chk("busy_start_no_err", BW'(err), BW'(0));
      chk("busy_start_no_sudo", BW'(slc.sudo_reset), BW'(0));
      chk("busy_start_busy", BW'(busy), BW'(1));
      fill_pulses(IC);
      b0 = n_beat; d0 = n_done; t = 0;
      while ((n_beat - b0 < 5) && (t < 50)) begin
         cyc();
         t++;
      end
      chk("abort_beats_before", BW'(n_beat - b0), BW'(5));
      abort = 1'b1;
      #1;
      chk("abort_read_drop", BW'(slc.image_read), BW'(0));
      cyc();
      abort = 1'b0;
      chk("abort_sudo", BW'(slc.sudo_reset), BW'(1));
      chk("abort_idle", BW'(busy), BW'(0));
      chk("abort_pe_valid", BW'(slc.pe_valid), BW'(0));
      chk("abort_conv_en", BW'(slc.conv_en), BW'(0));
      repeat (3) cyc();
      chk("abort_no_done", BW'(n_done - d0), BW'(0));
      chk("abort_sudo_one_cycle", BW'(slc.sudo_reset), BW'(0));
      chk("abort_err", BW'(err), BW'(0));
      exp_seq = slice_seq;

      // Illegal kernel at start.
      start = 1'b1; kernel_cfg = 3'd5; num_passes = 8'd1;
      cyc();
      start = 1'b0;
      chk("bad_kernel_err", BW'(err), BW'(1));
      chk("bad_kernel_sudo", BW'(slc.sudo_reset), BW'(1));
      chk("bad_kernel_busy", BW'(busy), BW'(0));
      cyc();
      chk("bad_kernel_sudo_pulse", BW'(slc.sudo_reset), BW'(0));
      chk("bad_kernel_err_sticky", BW'(err), BW'(1));
      run_job("after_bad", 3'd3, 8'd1, 1'b0, 1, 10);

      // Unrequested beat while idle.
      stray = 1'b1;
      cyc();
      stray = 1'b0;
      cyc();
      chk("stray_err", BW'(err), BW'(1));
      chk("stray_not_forwarded", BW'(slc.pe_valid), BW'(0));
      run_job("after_stray", 3'd6, 8'd1, 1'b0, 1, 40);

      // Reset asserted in the middle of a fill.
      start = 1'b1; kernel_cfg = 3'd6; num_passes = 8'd3;
      cyc();
      start = 1'b0;
      cyc();
      fill_pulses(4);
      reset = 1'b0;
      #1;
      chk("midrst_busy", BW'(busy), BW'(0));
      chk("midrst_conv_en", BW'(slc.conv_en), BW'(0));
      chk("midrst_kernel", BW'(slc.kernel), BW'(0));
      @(negedge clk);
      reset = 1'b1;
      cyc();
      chk("midrst_quiet", BW'({done, slc.sudo_reset, slc.im_valid_del, busy}), BW'(0));
      exp_seq = slice_seq;
      run_job("after_midrst", 3'd3, 8'd2, 1'b0, 2, 20);

`ifdef SLICE_CTRL_TIMEOUT_EN
      // Watchdog fires sixteen cycles after the last fill pulse.
      start = 1'b1; kernel_cfg = 3'd3; num_passes = 8'd1;
      cyc();
      start = 1'b0;
      cyc();
      fill_pulses(3);
      t = 0;
      while (busy && (t < 40)) begin
         cyc();
         t++;
      end
      chk("wdog_cycles", BW'(t), BW'(16));
      chk("wdog_err", BW'(err), BW'(1));
      chk("wdog_sudo", BW'(slc.sudo_reset), BW'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
